// File: rtl/countdown_timer_pkg.sv
// Shared constants for the countdown timer: default width and FSM state encodings.
package countdown_timer_pkg;

   localparam int unsigned CDT_WIDTH = 8;

   localparam logic [1:0] CDT_IDLE    = 2'd0;
   localparam logic [1:0] CDT_RUN     = 2'd1;
   localparam logic [1:0] CDT_EXPIRED = 2'd2;

endpackage

// File: rtl/countdown_fsm.sv
// Countdown timer control FSM: state register plus registered busy/done flags.
module countdown_fsm
   import countdown_timer_pkg::*;
(
   input  logic       clk,
   input  logic       Reset,
   input  logic       clr_i,
   input  logic       load_i,
   input  logic       load_zero_i,
   input  logic       stop_i,
   input  logic       start_i,
   input  logic       en_i,
   input  logic       count_nz_i,
   input  logic       count_one_i,
   input  logic       reload_nz_i,
   input  logic       wrap_i,
   output logic [1:0] state_o,
   output logic       busy_o,
   output logic       done_o
);

   logic [1:0] state_q, state_d;
   logic       busy_q, done_q;

   always_comb begin
      state_d = state_q;
      if (clr_i) begin
         state_d = CDT_IDLE;
      end else if (load_i) begin
         state_d = (state_q == CDT_RUN && !load_zero_i) ? CDT_RUN : CDT_IDLE;
      end else if (stop_i) begin
         if (state_q == CDT_RUN) state_d = CDT_IDLE;
      end else if (start_i) begin
         case (state_q)
            CDT_IDLE:    if (count_nz_i) state_d = CDT_RUN;
            CDT_EXPIRED: if (reload_nz_i) state_d = CDT_RUN;
            CDT_RUN:     state_d = CDT_RUN;
            default:     state_d = CDT_IDLE;
         endcase
      end else if (en_i && state_q == CDT_RUN && count_one_i) begin
         state_d = wrap_i ? CDT_RUN : CDT_EXPIRED;
      end else if (state_q == CDT_EXPIRED + 2'd1) begin
         // Unused encoding recovers to IDLE.
         state_d = CDT_IDLE;
      end
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state_q <= CDT_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         busy_q  <= (state_d == CDT_RUN);
         done_q  <= (state_d == CDT_EXPIRED);
      end
   end

   assign state_o = state_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with one-cycle UF pulse and sticky done.
// Define AUTO_RELOAD_EN to reload from the reload register at zero instead of expiring.
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int unsigned WIDTH = CDT_WIDTH
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic             CLR,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             start,
   input  logic             stop,
   input  logic             EN,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             UF
);

   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] reload_q, reload_d;
   logic             uf_q, uf_d;
   logic [1:0]       state;
   logic             count_nz, count_one, reload_nz, wrap;

   assign count_nz  = (count_q != '0);
   assign count_one = (count_q == WIDTH'(1));
   assign reload_nz = (reload_q != '0);

`ifdef AUTO_RELOAD_EN
   assign wrap = reload_nz;
`else
   assign wrap = 1'b0;
`endif

   always_comb begin
      count_d  = count_q;
      reload_d = reload_q;
      uf_d     = 1'b0;
      if (CLR) begin
         count_d = '0;
      end else if (load) begin
         count_d  = load_value;
         reload_d = load_value;
      end else if (stop) begin
         count_d = count_q;
      end else if (start) begin
         if (state == CDT_EXPIRED && reload_nz) count_d = reload_q;
      end else if (EN && state == CDT_RUN) begin
         if (count_one) begin
            uf_d    = 1'b1;
            count_d = wrap ? reload_q : '0;
         end else if (count_nz) begin
            count_d = count_q - WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         count_q  <= '0;
         reload_q <= '0;
         uf_q     <= 1'b0;
      end else begin
         count_q  <= count_d;
         reload_q <= reload_d;
         uf_q     <= uf_d;
      end
   end

   countdown_fsm u_fsm (
      .clk         (clk),
      .Reset       (Reset),
      .clr_i       (CLR),
      .load_i      (load),
      .load_zero_i (load_value == '0),
      .stop_i      (stop),
      .start_i     (start),
      .en_i        (EN),
      .count_nz_i  (count_nz),
      .count_one_i (count_one),
      .reload_nz_i (reload_nz),
      .wrap_i      (wrap),
      .state_o     (state),
      .busy_o      (busy),
      .done_o      (done)
   );

   assign count = count_q;
   assign UF    = uf_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer; expected {count,busy,done,UF} per cycle.
module tb_countdown_timer;

   logic       clk = 1'b0;
   logic       Reset, CLR, load, start, stop, EN;
   logic [7:0] load_value;
   logic [7:0] count;
   logic       busy, done, UF;

   logic [10:0] sb[$];
   logic [10:0] got, want;
   int          nvec = 0;
   int          nerr = 0;

   // Stimulus word: {CLR, load, stop, start, EN, load_value}.
   localparam logic [12:0] S_CLR = 13'h1000;
   localparam logic [12:0] S_LD  = 13'h0800;
   localparam logic [12:0] S_STP = 13'h0400;
   localparam logic [12:0] S_ST  = 13'h0200;
   localparam logic [12:0] S_EN  = 13'h0100;

   countdown_timer #(.WIDTH(8)) dut (
      .clk        (clk),
      .Reset      (Reset),
      .CLR        (CLR),
      .load       (load),
      .load_value (load_value),
      .start      (start),
      .stop       (stop),
      .EN         (EN),
      .count      (count),
      .busy       (busy),
      .done       (done),
      .UF         (UF)
   );

   always #5 clk = ~clk;

   task automatic cyc(input logic [12:0] s);
      {CLR, load, stop, start, EN} = s[12:8];
      load_value = s[7:0];
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      {CLR, load, stop, start, EN} = 5'b0;
      load_value = 8'd0;
      Reset = 1'b1;
      sb.push_back(11'd0);
      #10;
      got = {count, busy, done, UF}; want = sb.pop_front(); nvec++;
      if (got !== want) begin
         nerr++; $display("FAIL reset_held got=%h want=%h", got, want);
      end
      #4 Reset = 1'b0;
      sb.push_back(11'd0);
      @(posedge clk); #1;
      got = {count, busy, done, UF}; want = sb.pop_front(); nvec++;
      if (got !== want) begin
         nerr++; $display("FAIL reset_release got=%h want=%h", got, want);
      end
   endtask

`ifndef AUTO_RELOAD_EN
   localparam logic [12:0] OS_ST [6] = '{S_LD | 13'd3, S_ST, S_EN, S_EN, S_EN, S_EN};
   localparam logic [10:0] OS_EX [6] = '{{8'd3, 3'b000}, {8'd3, 3'b100}, {8'd2, 3'b100},
                                         {8'd1, 3'b100}, {8'd0, 3'b011}, {8'd0, 3'b010}};

   localparam logic [12:0] PS_ST [10] = '{S_LD | 13'd5, S_ST, S_EN, S_EN, S_STP | S_EN, S_EN,
                                          S_ST, S_EN, S_EN, S_EN};
   localparam logic [10:0] PS_EX [10] = '{{8'd5, 3'b000}, {8'd5, 3'b100}, {8'd4, 3'b100},
                                          {8'd3, 3'b100}, {8'd3, 3'b000}, {8'd3, 3'b000},
                                          {8'd3, 3'b100}, {8'd2, 3'b100}, {8'd1, 3'b100},
                                          {8'd0, 3'b011}};

   localparam logic [12:0] RA_ST [14] = '{S_LD | 13'd3, S_ST, S_EN, S_EN, S_EN, S_ST | S_EN,
                                          S_EN, S_CLR | S_LD | S_ST | S_EN | 13'd9, S_ST,
                                          S_LD | S_ST | S_EN | 13'd2, S_ST, S_STP | S_ST | S_EN,
                                          S_ST, S_LD | S_EN};
   localparam logic [10:0] RA_EX [14] = '{{8'd3, 3'b000}, {8'd3, 3'b100}, {8'd2, 3'b100},
                                          {8'd1, 3'b100}, {8'd0, 3'b011}, {8'd3, 3'b100},
                                          {8'd2, 3'b100}, {8'd0, 3'b000}, {8'd0, 3'b000},
                                          {8'd2, 3'b000}, {8'd2, 3'b100}, {8'd2, 3'b000},
                                          {8'd2, 3'b100}, {8'd0, 3'b000}};

   task automatic test_oneshot();
      for (int i = 0; i < 6; i++) begin
         sb.push_back(OS_EX[i]);
         cyc(OS_ST[i]);
         got = {count, busy, done, UF}; want = sb.pop_front(); nvec++;
         if (got !== want) begin
            nerr++; $display("FAIL oneshot[%0d] got=%h want=%h", i, got, want);
         end
      end
   endtask

   task automatic test_pause();
      for (int i = 0; i < 10; i++) begin
         sb.push_back(PS_EX[i]);
         cyc(PS_ST[i]);
         got = {count, busy, done, UF}; want = sb.pop_front(); nvec++;
         if (got !== want) begin
            nerr++; $display("FAIL pause[%0d] got=%h want=%h", i, got, want);
         end
      end
   endtask

   task automatic test_rearm_clr();
      for (int i = 0; i < 14; i++) begin
         sb.push_back(RA_EX[i]);
         cyc(RA_ST[i]);
         got = {count, busy, done, UF}; want = sb.pop_front(); nvec++;
         if (got !== want) begin
            nerr++; $display("FAIL rearm_clr[%0d] got=%h want=%h", i, got, want);
         end
      end
   endtask
`else
   task automatic test_auto_reload();
      logic [12:0] s;
      logic [7:0]  c;
      for (int i = 0; i < 14; i++) begin
         s = (i == 0) ? (S_LD | 13'd4) : (i == 1) ? S_ST : S_EN;
         c = (i < 2) ? 8'd4 : 8'(4 - ((i - 1) % 4));
         if (i == 0) sb.push_back({c, 3'b000});
         else sb.push_back({c, 2'b10, (i >= 2 && (i - 1) % 4 == 0)});
         cyc(s);
         got = {count, busy, done, UF}; want = sb.pop_front(); nvec++;
         if (got !== want) begin
            nerr++; $display("FAIL auto_reload[%0d] got=%h want=%h", i, got, want);
         end
      end
   endtask
`endif

   localparam logic [12:0] ZR_ST [7] = '{S_LD, S_ST, S_ST | S_EN, S_LD | 13'd4, S_ST, S_EN, S_EN};
   localparam logic [10:0] ZR_EX [7] = '{{8'd0, 3'b000}, {8'd0, 3'b000}, {8'd0, 3'b000},
                                         {8'd4, 3'b000}, {8'd4, 3'b100}, {8'd3, 3'b100},
                                         {8'd2, 3'b100}};

   task automatic test_zero_cases();
      for (int i = 0; i < 7; i++) begin
         sb.push_back(ZR_EX[i]);
         cyc(ZR_ST[i]);
         got = {count, busy, done, UF}; want = sb.pop_front(); nvec++;
         if (got !== want) begin
            nerr++; $display("FAIL zero[%0d] got=%h want=%h", i, got, want);
         end
      end
      // Asynchronous abort mid-count with EN still high.
      #2 Reset = 1'b1;
      sb.push_back(11'd0);
      #1;
      got = {count, busy, done, UF}; want = sb.pop_front(); nvec++;
      if (got !== want) begin
         nerr++; $display("FAIL async_reset got=%h want=%h", got, want);
      end
      sb.push_back(11'd0);
      @(posedge clk); #1;
      got = {count, busy, done, UF}; want = sb.pop_front(); nvec++;
      if (got !== want) begin
         nerr++; $display("FAIL reset_hold_en got=%h want=%h", got, want);
      end
      Reset = 1'b0;
      sb.push_back(11'd0);
      cyc(S_ST | S_EN);
      got = {count, busy, done, UF}; want = sb.pop_front(); nvec++;
      if (got !== want) begin
         nerr++; $display("FAIL start_after_reset got=%h want=%h", got, want);
      end
   endtask

   initial begin
      test_reset();
`ifndef AUTO_RELOAD_EN
      test_oneshot();
      test_pause();
      test_rearm_clr();
`else
      test_auto_reload();
`endif
      test_zero_cases();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule
